// File: rtl/root_up_collector_pkg.sv
// root_up_collector_pkg: shared flit constants and arbiter state type for the upstream collector.
package root_up_collector_pkg;
    localparam int FLIT_W = 64;
    localparam int FLIT_LAST_BIT = 63;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/root_up_collector_rr_priority_pick.sv
// rr_priority_pick: first set request at or after start, wrapping, as a leaf index.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] grant,
    output logic         any_req
);
    logic [2*N-1:0] rot;
    logic [W:0]     sum;
    always_comb begin
        rot = {req, req} >> start;
        sum = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, start} + (W+1)'(k);
        grant = W'(sum >= (W+1)'(N) ? sum - (W+1)'(N) : sum);
        any_req = |req;
    end
endmodule

// File: rtl/root_up_collector.sv
// root_up_collector: round-robin merge of leaf upstream links into one tagged stream,
// holding a leaf's grant until its LAST flit so messages never interleave.
module root_up_collector
    import root_up_collector_pkg::*;
#(
    parameter int NUM_LEAVES = 4,
    parameter int LEAF_ID_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FLIT_W*NUM_LEAVES-1:0] up_rx_data,
    input  logic [NUM_LEAVES-1:0]        up_rx_valid,
    output logic [NUM_LEAVES-1:0]        up_rx_ready,
    output logic [FLIT_W-1:0]            out_data,
    output logic [LEAF_ID_W-1:0]         out_leaf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);
    arb_state_t                   state, state_n;
    logic [LEAF_ID_W-1:0]         rr_ptr, rr_ptr_n, lock_leaf, lock_leaf_n, gnt;
    logic [NUM_LEAVES-1:0]        full, req, drain;
    logic [FLIT_W*NUM_LEAVES-1:0] skid_flat;
    logic [FLIT_W-1:0]            gnt_data;
    logic                         any_req, load_out, grant_v;

    assign load_out = !out_valid || out_ready;
    assign grant_v  = load_out && any_req;
    assign busy     = |full || out_valid || state == LOCKED;

    // While locked only the owning leaf may request, so the search start is moot.
    assign req = state == LOCKED ? full & (NUM_LEAVES'(1) << lock_leaf) : full;

    rr_priority_pick #(.N(NUM_LEAVES), .W(LEAF_ID_W)) u_pick (
        .req    (req),
        .start  (rr_ptr),
        .grant  (gnt),
        .any_req(any_req)
    );

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_skid
        logic              full_q;
        logic [FLIT_W-1:0] data_q;
        assign drain[i]                      = grant_v && gnt == LEAF_ID_W'(i);
        assign up_rx_ready[i]                = !full_q || drain[i];
        assign full[i]                       = full_q;
        assign skid_flat[i*FLIT_W +: FLIT_W] = data_q;
        // A draining entry refills in the same cycle so one leaf can stream at full rate.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else if (up_rx_valid[i] && up_rx_ready[i]) begin
                full_q <= 1'b1;
                data_q <= up_rx_data[i*FLIT_W +: FLIT_W];
            end else if (drain[i]) begin
                full_q <= 1'b0;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_LEAVES; i++)
            if (gnt == LEAF_ID_W'(i)) gnt_data = skid_flat[i*FLIT_W +: FLIT_W];
    end

    always_comb begin
        state_n     = state;
        lock_leaf_n = lock_leaf;
        rr_ptr_n    = rr_ptr;
        if (grant_v) begin
            state_n     = gnt_data[FLIT_LAST_BIT] ? IDLE : LOCKED;
            lock_leaf_n = gnt;
            if (state == IDLE)
                rr_ptr_n = gnt == LEAF_ID_W'(NUM_LEAVES - 1) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lock_leaf <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_leaf  <= '0;
        end else begin
            state     <= state_n;
            lock_leaf <= lock_leaf_n;
            rr_ptr    <= rr_ptr_n;
            if (load_out) out_valid <= grant_v;
            if (grant_v) begin
                out_data <= gnt_data;
                out_leaf <= gnt;
            end
        end
    end
endmodule

// File: tb/tb_root_up_collector.sv
// tb_root_up_collector: directed checks of latency, round-robin order, message locking,
// backpressure, async reset and a randomized ordering soak.
module tb_root_up_collector;
    localparam int N  = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*64-1:0] up_rx_data = '0;
    logic [N-1:0]    up_rx_valid = '0;
    logic [N-1:0]    up_rx_ready;
    logic [63:0]     out_data;
    logic [LW-1:0]   out_leaf;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            busy;

    typedef struct packed {
        logic [LW-1:0] leaf;
        logic [63:0]   data;
    } rec_t;

    logic [63:0]  src_q [N][$];
    rec_t         got[$];
    logic [N-1:0] en = '1;
    logic [N-1:0] hs = '0;
    int           pass_cnt = 0;
    int           total = 0;

    always #5 clk = ~clk;

    root_up_collector #(.NUM_LEAVES(N), .LEAF_ID_W(LW)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .up_rx_data (up_rx_data),
        .up_rx_valid(up_rx_valid),
        .up_rx_ready(up_rx_ready),
        .out_data   (out_data),
        .out_leaf   (out_leaf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // Handshakes and output transfers are judged mid-cycle, ahead of the edge that commits them.
    initial forever begin
        @(negedge clk);
        hs = rst_n ? up_rx_valid & up_rx_ready : '0;
        if (rst_n && out_valid && out_ready) got.push_back(rec_t'{out_leaf, out_data});
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            up_rx_valid[i] = rst_n && en[i] && src_q[i].size() > 0;
            up_rx_data[i*64 +: 64] = src_q[i].size() > 0 ? src_q[i][0] : 64'h0;
        end
        hs = '0;
    end

    function automatic logic [63:0] mk(input logic last, input int leaf, input int seq);
        return {last, 39'h0, 8'(leaf), 16'(seq)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_got(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) step(1);
        chk(tag, 64'(got.size()), 64'(n));
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_q[i].delete();
        up_rx_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        step(2);
        got.delete();
        rst_n = 1'b1;
        step(1);
    endtask

    // Per-leaf sequence numbers must run 0,1,2.. and an open message must not be interrupted.
    task automatic audit(output int bad, output int inter);
        int   nxt [N];
        logic open;
        int   cur;
        bad = 0;
        inter = 0;
        open = 1'b0;
        cur = 0;
        for (int i = 0; i < N; i++) nxt[i] = 0;
        foreach (got[k]) begin
            int l;
            l = int'(got[k].leaf);
            if (l >= N || int'(got[k].data[23:16]) != l) bad++;
            else begin
                if (int'(got[k].data[15:0]) != nxt[l]) bad++;
                nxt[l] = int'(got[k].data[15:0]) + 1;
            end
            if (open && l != cur) inter++;
            open = !got[k].data[63];
            cur = l;
        end
    endtask

    initial begin
        int bad, inter, nflits;
        int exp_leaf [7] = '{0, 1, 1, 1, 0, 0, 0};
        step(1);
        chk("reset_ready", 64'(up_rx_ready), 64'hF);
        chk("reset_valid", 64'(out_valid), 64'h0);
        chk("reset_data", out_data, 64'h0);
        chk("reset_leaf", 64'(out_leaf), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        step(1);

        src_q[2].push_back(64'h8000_0000_0000_00AB);
        step(2);
        chk("single_not_early", 64'(out_valid), 64'h0);
        step(1);
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_data", out_data, 64'h8000_0000_0000_00AB);
        chk("single_leaf", 64'(out_leaf), 64'h2);
        step(1);
        chk("single_drained", 64'(out_valid), 64'h0);
        chk("single_busy", 64'(busy), 64'h0);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            got.delete();
            for (int i = 0; i < N; i++) src_q[i].push_back(mk(1'b1, i, r));
            wait_got("rr_count", 4, 30);
            for (int i = 0; i < 4 && i < got.size(); i++)
                chk($sformatf("rr%0d_slot%0d", r, i), 64'(got[i].leaf), 64'(i));
        end

        got.delete();
        src_q[1].push_back(mk(1'b0, 1, 0));
        src_q[1].push_back(mk(1'b0, 1, 1));
        src_q[1].push_back(mk(1'b1, 1, 2));
        for (int s = 0; s < 4; s++) src_q[0].push_back(mk(1'b1, 0, s));
        wait_got("lock_count", 7, 40);
        for (int i = 0; i < 7 && i < got.size(); i++)
            chk($sformatf("lock_slot%0d", i), 64'(got[i].leaf), 64'(exp_leaf[i]));
        if (got.size() >= 4) chk("lock_tail_data", got[3].data, mk(1'b1, 1, 2));

        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++)
            for (int s = 0; s < 6; s++) src_q[i].push_back(mk(1'b1, i, s));
        step(10);
        chk("bp_ready_low", 64'(up_rx_ready), 64'h0);
        chk("bp_out_held", 64'(out_valid), 64'h1);
        chk("bp_busy", 64'(busy), 64'h1);
        for (int k = 0; k < 200 && got.size() < 24; k++) begin
            out_ready = ~out_ready;
            step(1);
        end
        out_ready = 1'b1;
        step(2);
        chk("bp_count", 64'(got.size()), 64'd24);
        audit(bad, inter);
        chk("bp_order", 64'(bad), 64'h0);

        do_reset();
        got.delete();
        src_q[3].push_back(mk(1'b0, 3, 0));
        src_q[3].push_back(mk(1'b0, 3, 1));
        src_q[3].push_back(mk(1'b0, 3, 2));
        src_q[3].push_back(mk(1'b1, 3, 3));
        step(3);
        chk("ar_pre_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_ready", 64'(up_rx_ready), 64'hF);
        chk("ar_busy", 64'(busy), 64'h0);
        clear_src();
        step(2);
        got.delete();
        rst_n = 1'b1;
        step(1);
        src_q[3].push_back(mk(1'b1, 3, 0));
        src_q[0].push_back(mk(1'b1, 0, 0));
        wait_got("ar_count", 2, 20);
        if (got.size() >= 2) begin
            chk("ar_first_leaf", 64'(got[0].leaf), 64'h0);
            chk("ar_second_data", got[1].data, mk(1'b1, 3, 0));
        end

        do_reset();
        nflits = 0;
        for (int i = 0; i < N; i++) begin
            int seq;
            seq = 0;
            for (int m = 0; m < 250; m++) begin
                int len;
                len = int'($urandom_range(4, 1));
                for (int f = 0; f < len; f++) begin
                    src_q[i].push_back(mk(f == len - 1, i, seq));
                    seq++;
                end
            end
            nflits += seq;
        end
        for (int k = 0; k < 40000 && got.size() < nflits; k++) begin
            en = N'($urandom);
            out_ready = 1'($urandom);
            step(1);
        end
        en = '1;
        out_ready = 1'b1;
        step(3);
        chk("soak_count", 64'(got.size()), 64'(nflits));
        audit(bad, inter);
        chk("soak_order", 64'(bad), 64'h0);
        chk("soak_interleave", 64'(inter), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
